ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter. It sends one command byte to the keyboard, for example 0xED (set LEDs) or 0xFF (reset). It runs in the system clock domain and drives the bus through open-drain low-enables. It sits beside the PS/2 receiver, and its busy output tells the receiver to ignore bus activity during a transmission.

---
 rtl/ps2_pkg.sv | 29 ++
 rtl/ps2_sync_edge.sv | 30 +++
 rtl/ps2_host_tx.sv | 174 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, command/response bytes
// and small helpers used by the host transmitter and receiver.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } ps2_state_t;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_RESP_ACK     = 8'hFA;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // PS/2 frames carry odd parity over the 8 data bits
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for a raw PS/2 line plus falling-edge detect on the
// synchronized value. Flops reset high to match an idle (released) bus.
module ps2_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_line,
    output logic o_sync,
    output logic o_fall_c
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_line;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync   = r_sync;
    assign o_fall_c = r_prev & ~r_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a request-to-send,
// shifts out one command byte on device clock falls and checks the device ACK.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_drive_low,
    output logic       ps2_data_drive_low
);

    localparam int unsigned CNT_W = $clog2(max_u(INHIBIT_CYCLES, TIMEOUT_CYCLES) + 1);

    ps2_state_t r_state;
    ps2_state_t w_state_next;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [3:0]       r_bit_idx;
    logic [3:0]       w_bit_idx_next;
    logic [7:0]       r_data;
    logic             r_parity;
    logic             r_clk_low;
    logic             r_data_low;
    logic             r_tx_done;
    logic             r_tx_error;
    logic             r_tx_ready;
    logic             r_busy;
    logic             w_clk_low_next;
    logic             w_data_low_next;
    logic             w_done_next;
    logic             w_error_next;
    logic             w_ready_next;
    logic             w_busy_next;

    logic w_clk_sync;
    logic w_fall;
    logic w_data_sync;
    logic w_data_fall_unused;
    logic w_accept;
    logic w_timeout;

    ps2_sync_edge u_clk_sync (
        .clk      (clk),
        .rst      (rst),
        .i_line   (ps2_clk_in),
        .o_sync   (w_clk_sync),
        .o_fall_c (w_fall)
    );

    ps2_sync_edge u_data_sync (
        .clk      (clk),
        .rst      (rst),
        .i_line   (ps2_data_in),
        .o_sync   (w_data_sync),
        .o_fall_c (w_data_fall_unused)
    );

    assign w_accept  = (r_state == IDLE) && tx_valid && r_tx_ready;
    // A fall in the same cycle as the limit counts as activity, not a timeout
    assign w_timeout = !w_fall && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:      if (w_accept) w_state_next = INHIBIT;
            INHIBIT:   if (r_cnt == CNT_W'(INHIBIT_CYCLES - 1)) w_state_next = REQ;
            REQ:       if (w_fall) w_state_next = DATA;
                       else if (w_timeout) w_state_next = IDLE;
            DATA:      if (w_fall && (r_bit_idx == 4'd8)) w_state_next = PARITY;
                       else if (w_timeout) w_state_next = IDLE;
            PARITY:    if (w_fall) w_state_next = STOP;
                       else if (w_timeout) w_state_next = IDLE;
            STOP:      if (w_fall) w_state_next = w_data_sync ? IDLE : WAIT_IDLE;
                       else if (w_timeout) w_state_next = IDLE;
            WAIT_IDLE: if ((w_clk_sync && w_data_sync) || w_timeout) w_state_next = IDLE;
            default:   w_state_next = IDLE;
        endcase
    end

    // Next values for the registered bus drives, pulses and counters
    always_comb begin
        w_cnt_next      = r_cnt + CNT_W'(1);
        w_bit_idx_next  = r_bit_idx;
        w_data_low_next = r_data_low;
        w_clk_low_next  = (w_state_next == INHIBIT);
        w_done_next     = 1'b0;
        w_error_next    = 1'b0;
        w_ready_next    = (r_state == IDLE) && (w_state_next == IDLE);
        w_busy_next     = (w_state_next != IDLE);

        if ((w_state_next != r_state) || (r_state == IDLE)) w_cnt_next = '0;
        else if (w_fall && (r_state != INHIBIT))            w_cnt_next = '0;

        case (r_state)
            IDLE: w_bit_idx_next = '0;
            REQ: if (w_fall) begin
                w_data_low_next = ~r_data[0];
                w_bit_idx_next  = 4'd1;
            end
            DATA: if (w_fall) begin
                if (r_bit_idx == 4'd8) begin
                    w_data_low_next = ~r_parity;
                end else begin
                    w_data_low_next = ~r_data[r_bit_idx[2:0]];
                    w_bit_idx_next  = r_bit_idx + 4'd1;
                end
            end
            PARITY: if (w_fall) w_data_low_next = 1'b0;
            WAIT_IDLE: w_done_next = w_clk_sync && w_data_sync;
            default: ;
        endcase

        if ((r_state inside {REQ, DATA, PARITY, STOP, WAIT_IDLE}) &&
            (w_state_next == IDLE) && !w_done_next)
            w_error_next = 1'b1;
        if (w_state_next == INHIBIT)
            w_data_low_next = (w_cnt_next == CNT_W'(INHIBIT_CYCLES - 1));
        if (w_state_next == IDLE)
            w_data_low_next = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_data     <= '0;
            r_parity   <= 1'b0;
            r_clk_low  <= 1'b0;
            r_data_low <= 1'b0;
            r_tx_done  <= 1'b0;
            r_tx_error <= 1'b0;
            r_tx_ready <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_next;
            r_bit_idx  <= w_bit_idx_next;
            r_clk_low  <= w_clk_low_next;
            r_data_low <= w_data_low_next;
            r_tx_done  <= w_done_next;
            r_tx_error <= w_error_next;
            r_tx_ready <= w_ready_next;
            r_busy     <= w_busy_next;
            if (w_accept) begin
                r_data   <= tx_data;
                r_parity <= odd_parity(tx_data);
            end
        end
    end

    assign tx_ready           = r_tx_ready;
    assign busy               = r_busy;
    assign tx_done            = r_tx_done;
    assign tx_error           = r_tx_error;
    assign ps2_clk_drive_low  = r_clk_low;
    assign ps2_data_drive_low = r_data_low;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain bus with a PS/2 device model that clocks
// frames in, plus a scoreboard of the bytes and outcomes each request should give.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int unsigned INH = 40;
    localparam int unsigned TO  = 300;
    localparam int          H   = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, tx_done, tx_error;
    logic       ps2_clk_drive_low, ps2_data_drive_low;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       bus_clk, bus_data;

    assign bus_clk  = ~(ps2_clk_drive_low | dev_clk_low);
    assign bus_data = ~(ps2_data_drive_low | dev_data_low);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk                (clk),
        .rst                (rst),
        .tx_data            (tx_data),
        .tx_valid           (tx_valid),
        .tx_ready           (tx_ready),
        .busy               (busy),
        .tx_done            (tx_done),
        .tx_error           (tx_error),
        .ps2_clk_in         (bus_clk),
        .ps2_data_in        (bus_data),
        .ps2_clk_drive_low  (ps2_clk_drive_low),
        .ps2_data_drive_low (ps2_data_drive_low)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] cmd;
        logic       ack;
        logic       par;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       ack;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[4];
    int   n_vec = 0;
    int   n_err = 0;
    int   done_cnt = 0;
    int   err_cnt = 0;
    int   both_cnt = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (tx_done) done_cnt <= done_cnt + 1;
            if (tx_error) err_cnt <= err_cnt + 1;
            if (tx_done && tx_error) both_cnt <= both_cnt + 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic send_req(input logic [7:0] cmd);
        int t;
        t = 0;
        @(negedge clk);
        while (!tx_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("ready_before_send", int'(tx_ready), 1);
        tx_data  = cmd;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Device side: measures the inhibit, then clocks npulse falls, sampling on each rise
    task automatic dev_frame(input logic ack, input int npulse, output logic [7:0] d,
                             output logic p, output logic st, output int inh, output int dl);
        int t;
        logic [9:0] bits;
        bits = '1;
        inh  = 0;
        dl   = 0;
        t    = 0;
        while (bus_clk && t < 50) begin
            @(negedge clk);
            t++;
        end
        while (!bus_clk && inh < 10 * int'(INH)) begin
            inh++;
            if (!bus_data) dl++;
            @(negedge clk);
        end
        chk("start_bit", int'(bus_data), 0);
        for (int k = 0; k < npulse; k++) begin
            if (k == 10 && ack) dev_data_low = 1'b1;
            repeat (H) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (H) @(negedge clk);
            if (k < 10) bits[4'(k)] = bus_data;
            dev_clk_low  = 1'b0;
            dev_data_low = 1'b0;
        end
        d  = bits[7:0];
        p  = bits[8];
        st = bits[9];
    endtask

    task automatic finish_frame();
        int d0, e0, inh, dl, t;
        logic [7:0] d;
        logic p, st;
        exp_t e;
        d0 = done_cnt;
        e0 = err_cnt;
        e  = sb.pop_front();
        dev_frame(e.ack, 11, d, p, st, inh, dl);
        t = 0;
        while (done_cnt == d0 && err_cnt == e0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        repeat (5) @(negedge clk);
        chk("inhibit_len", inh, int'(INH));
        chk("inhibit_data_low_cycles", dl, 1);
        chk("data_byte", int'(d), int'(e.data));
        chk("parity_bit", int'(p), int'(e.par));
        chk("stop_bit", int'(st), 1);
        chk("done_pulses", done_cnt - d0, e.ack ? 1 : 0);
        chk("error_pulses", err_cnt - e0, e.ack ? 0 : 1);
        chk("clk_released", int'(ps2_clk_drive_low), 0);
        chk("data_released", int'(ps2_data_drive_low), 0);
        chk("ready_after", int'(tx_ready), 1);
        chk("busy_after", int'(busy), 0);
    endtask

    task automatic xfer(input logic [7:0] cmd, input logic ack, input logic par);
        send_req(cmd);
        sb.push_back('{cmd, par, ack});
        finish_frame();
    endtask

    initial begin
        int t, n, d0, e0, inh, dl;
        logic [7:0] d;
        logic p, st;
        exp_t e;

        vecs[0] = '{PS2_CMD_SET_LEDS, 1'b1, 1'b1};
        vecs[1] = '{PS2_CMD_ENABLE,   1'b1, 1'b0};
        vecs[2] = '{8'h00,            1'b1, 1'b1};
        vecs[3] = '{8'h3C,            1'b0, 1'b1};

        repeat (3) @(negedge clk);
        chk("rst_ready", int'(tx_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(tx_done), 0);
        chk("rst_error", int'(tx_error), 0);
        chk("rst_clk_low", int'(ps2_clk_drive_low), 0);
        chk("rst_data_low", int'(ps2_data_drive_low), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 4; i++) xfer(vecs[i].cmd, vecs[i].ack, vecs[i].par);

        // tx_valid stays high with a second byte across a whole transfer
        sb.push_back('{PS2_CMD_SET_LEDS, 1'b1, 1'b1});
        d0 = done_cnt;
        e0 = err_cnt;
        @(negedge clk);
        tx_data  = PS2_CMD_SET_LEDS;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'h11;
        e = sb.pop_front();
        dev_frame(e.ack, 11, d, p, st, inh, dl);
        t = 0;
        while (!tx_done && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("ovl_done_seen", int'(tx_done), 1);
        chk("ovl_ready_at_done", int'(tx_ready), 0);
        @(negedge clk);
        chk("ovl_ready_next", int'(tx_ready), 1);
        @(negedge clk);
        tx_valid = 1'b0;
        chk("ovl_busy_after_accept", int'(busy), 1);
        chk("ovl_data_byte", int'(d), int'(e.data));
        chk("ovl_parity_bit", int'(p), int'(e.par));
        chk("ovl_error_pulses", err_cnt - e0, 0);
        sb.push_back('{8'h11, 1'b1, 1'b1});
        finish_frame();

        // Device never clocks after the request
        d0 = done_cnt;
        send_req(PS2_CMD_SET_LEDS);
        t = 0;
        while (ps2_clk_drive_low && t < 10 * int'(INH)) begin
            @(negedge clk);
            t++;
        end
        n = 0;
        while (!tx_error && n < int'(TO) + 50) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_latency_ok", int'(n >= int'(TO) - 2 && n <= int'(TO) + 2), 1);
        chk("timeout_clk_released", int'(ps2_clk_drive_low), 0);
        chk("timeout_data_released", int'(ps2_data_drive_low), 0);
        repeat (3) @(negedge clk);
        chk("timeout_ready", int'(tx_ready), 1);
        chk("timeout_no_done", done_cnt - d0, 0);

        // Asynchronous reset while the clock line is inhibited
        send_req(PS2_CMD_ENABLE);
        repeat (5) @(negedge clk);
        chk("inh_clk_low", int'(ps2_clk_drive_low), 1);
        #2 rst = 1'b1;
        #1;
        chk("inh_rst_clk_low", int'(ps2_clk_drive_low), 0);
        chk("inh_rst_data_low", int'(ps2_data_drive_low), 0);
        chk("inh_rst_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Asynchronous reset after four data bits of 0x00
        send_req(8'h00);
        dev_frame(1'b0, 4, d, p, st, inh, dl);
        chk("mid_data_low", int'(ps2_data_drive_low), 1);
        chk("mid_busy", int'(busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_data_low", int'(ps2_data_drive_low), 0);
        chk("mid_rst_clk_low", int'(ps2_clk_drive_low), 0);
        chk("mid_rst_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        xfer(PS2_CMD_RESET, 1'b1, 1'b1);

        chk("done_and_error_together", both_cnt, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
